// File: rtl/forwarding_scoreboard_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : forwarding_scoreboard_if
// Purpose  : ID-side issue/hazard bundle between the decode stage and the
//            forwarding scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface forwarding_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int NSRC   = 2,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    localparam int SELW = $clog2(STAGES);

    logic                    issue_valid_i;
    logic                    issue_regwrite_i;
    logic                    issue_is_load_i;
    logic [REG_W-1:0]        issue_rd_i;
    logic [NSRC*REG_W-1:0]   id_rs_i;
    logic [NSRC-1:0]         id_rs_use_i;
    logic                    hold_i;
    logic                    flush_i;
    logic                    stall_o;
    logic [NSRC*SELW-1:0]    fwd_sel_o;
    logic [CNT_W-1:0]        stall_cnt_o;

    modport master (
        output issue_valid_i, issue_regwrite_i, issue_is_load_i, issue_rd_i,
        output id_rs_i, id_rs_use_i, hold_i, flush_i,
        input  stall_o, fwd_sel_o, stall_cnt_o
    );

    modport slave (
        input  issue_valid_i, issue_regwrite_i, issue_is_load_i, issue_rd_i,
        input  id_rs_i, id_rs_use_i, hold_i, flush_i,
        output stall_o, fwd_sel_o, stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/forwarding_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : forwarding_scoreboard
// Purpose  : Tracks in-flight destination tags beside ID, raises load-use
//            stalls and registers per-source forwarding selects for EX.
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_scoreboard #(
    parameter int STAGES   = 3,
    parameter int NSRC     = 2,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    forwarding_scoreboard_if.slave bus
);
    localparam int SELW  = $clog2(STAGES);
    localparam int NSLOT = STAGES - 1;
    localparam logic [SELW-1:0] RDY_ALU  = SELW'(1);
    localparam logic [SELW-1:0] RDY_LOAD = SELW'(1 + LOAD_LAT);

    logic [NSLOT-1:0]                vld_q, vld_d;
    logic [NSLOT-1:0]                wr_q,  wr_d;
    logic [NSLOT-1:0][REG_W-1:0]     rd_q,  rd_d;
    logic [NSLOT-1:0][SELW-1:0]      rdy_q, rdy_d;
    logic [NSRC-1:0][SELW-1:0]       sel_q, sel_d, sel_nxt;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NSRC-1:0]                 hazard;
    logic                            stall;

    // Scanning from the oldest slot down lets the youngest producer overwrite.
    always_comb begin
        logic [REG_W-1:0] rs;
        logic             hit;
        logic [SELW-1:0]  win_sel;
        logic [SELW-1:0]  win_rdy;
        rs      = '0;
        hit     = 1'b0;
        win_sel = '0;
        win_rdy = '0;
        hazard  = '0;
        sel_nxt = '0;
        for (int j = 0; j < NSRC; j++) begin
            rs      = bus.id_rs_i[j*REG_W +: REG_W];
            hit     = 1'b0;
            win_sel = '0;
            win_rdy = '0;
            for (int s = NSLOT - 1; s >= 0; s--) begin
                if (vld_q[s] && wr_q[s] && (rd_q[s] == rs)) begin
                    hit     = 1'b1;
                    win_sel = SELW'(s + 1);
                    win_rdy = rdy_q[s];
                end
            end
            if (hit && (rs != '0) && bus.id_rs_use_i[j] && bus.issue_valid_i) begin
                if (win_sel < win_rdy) begin
                    hazard[j] = 1'b1;
                end else begin
                    sel_nxt[j] = win_sel;
                end
            end
        end
    end

    assign stall = (|hazard) && !bus.flush_i;

    always_comb begin
        vld_d = vld_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        rdy_d = rdy_q;
        sel_d = sel_q;
        cnt_d = cnt_q;
        if (!bus.hold_i) begin
            for (int k = NSLOT - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                wr_d[k]  = wr_q[k-1];
                rd_d[k]  = rd_q[k-1];
                rdy_d[k] = rdy_q[k-1];
            end
            vld_d[0] = 1'b0;
            wr_d[0]  = 1'b0;
            rd_d[0]  = '0;
            rdy_d[0] = RDY_ALU;
            sel_d    = '0;
            if (stall) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (!bus.flush_i) begin
                vld_d[0] = bus.issue_valid_i;
                wr_d[0]  = bus.issue_regwrite_i;
                rd_d[0]  = bus.issue_rd_i;
                rdy_d[0] = bus.issue_is_load_i ? RDY_LOAD : RDY_ALU;
                sel_d    = sel_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            rdy_q <= '0;
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            rdy_q <= rdy_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall_o     = stall;
    assign bus.fwd_sel_o   = sel_q;
    assign bus.stall_cnt_o = cnt_q;
endmodule
`default_nettype wire

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised, stateful operand-forwarding and hazard unit for the in-order pipeline. It sits beside the ID stage. It tracks destination tags of in-flight instructions in an internal shift pipeline, so no EX/MEM or MEM/WB register fields need to be routed back to it. The forwarding selects it emits are registered so they are valid when the instruction reaches EX. Over a fixed two-source forwarding check, it adds three things: configurable depth and source count, load-latency-aware stall generation, and pipeline hold and flush handling.

## Interface
- STAGES, 3: tracked stages from EX through WB (EX=slot 0, WB=slot STAGES-1). Minimum 2.
- NSRC, 2: source operands per instruction.
- REG_W, 5: register-address width.
- LOAD_LAT, 1: extra cycles before a load result becomes forwardable. Must satisfy 1+LOAD_LAT <= STAGES-1.
- CNT_W, 16: width of the stall counter.
- SELW, derived: $clog2(STAGES). Not overridable.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- issue_valid_i  input  1  ID holds a valid instruction.
- issue_regwrite_i  input  1  ID instruction writes rd.
- issue_is_load_i  input  1  ID instruction is a load.
- issue_rd_i  input  REG_W  ID destination register.
- id_rs_i  input  NSRC*REG_W  ID source registers; source j is at [j*REG_W +: REG_W].
- id_rs_use_i  input  NSRC  per-source "operand is read" mask.
- hold_i  input  1  global pipeline freeze, e.g. memory wait.
- flush_i  input  1  kill the ID instruction (branch taken).
- stall_o  output  1  combinational load-use hazard; freeze PC/IF/ID and inject an EX bubble.
- fwd_sel_o  output  NSRC*SELW  registered per-source select for EX. 0 = register-file value; k (1..STAGES-1) = result held by the instruction in slot k.
- stall_cnt_o  output  CNT_W  saturating count of cycles with stall_o=1 and hold_i=0.

## Operation
- Tag store: slots 0..STAGES-2. Each slot holds {valid, wr, rd, rdy}.
  - rdy is the first slot index at which the result is forwardable: 1 for non-loads, 1+LOAD_LAT for loads.
  - WB (slot STAGES-1) is not stored. The register file is write-through, so an ID read in the same cycle sees the WB value.
- Match rule for source j:
  - Candidate slots s satisfy: valid && wr && rd==rs_j && rd!=0 && id_rs_use_i[j] && issue_valid_i.
  - The smallest s (youngest producer) wins. Older matches are ignored.
- Hazard: a source hazards if its winning slot has s+1 < rdy.
  - stall_o = OR over sources of the hazard.
  - stall_o is forced to 0 when flush_i=1.
- Next select for source j:
  - s+1 if a match exists and there is no hazard.
  - Otherwise 0, which covers no match, rs==0, and unused sources.
- Per-edge update, in priority order:
  - rst_i: all slot valids cleared, fwd_sel_o=0, stall_cnt_o=0.
  - hold_i=1: slots, fwd_sel_o and counter all unchanged. stall_o is still driven from the current state.
  - flush_i=1: slots shift (slot k ← slot k-1), slot 0 ← bubble, fwd_sel_o ← 0.
  - stall_o=1: slots shift, slot 0 ← bubble, fwd_sel_o ← 0, counter increments.
  - Otherwise: slots shift. Slot 0 ← {issue_valid_i, issue_regwrite_i, issue_rd_i, rdy}. fwd_sel_o ← next selects.
- Counter: saturates at all-ones and does not wrap.

## Timing
- Forwarding latency:
  - Selects are computed in the cycle the instruction is in ID.
  - They appear on fwd_sel_o the next cycle, while the instruction is in EX.
  - They stay constant across hold cycles.
- Stall timing:
  - stall_o is purely combinational from the current slots and ID inputs; there is no registered delay.
  - A load followed immediately by a dependent instruction gives LOAD_LAT stall cycles. Each stall cycle advances the load one slot.
  - The dependent instruction reaches EX with fwd_sel = 1+LOAD_LAT.
- Reset values: stall_o=0, because no slot is valid. fwd_sel_o and stall_cnt_o are all zero.
- Reset mid-stall: the state clears immediately and asynchronously. The stall deasserts in the same cycle.
- A bubble slot never matches. Back-to-back hazards on both sources count as one stall cycle, not two.

## Test plan
- ALU chain (default parameters): ADD r3 then SUB r4,r3,r3 back-to-back.
  - Required: stall_o=0; in SUB's EX cycle fwd_sel_o={2'd1,2'd1}.
- Load-use: LW r5 then ADD r6,r5,r0.
  - Required: stall_o=1 for exactly 1 cycle and stall_cnt_o=1.
  - Then ADD reaches EX with src0 sel=2 and src1 sel=0 (r0).
- Distance and priority: writers of r7 at distances 1 and 2, then a reader of r7.
  - Required: sel=1, the youngest writer.
  - Writer at distance 3 only: sel=0.
  - rd=0 writer at distance 1: sel=0.
- Hold: assert hold_i for 4 cycles while a dependent instruction is in EX with sel=1.
  - Required: fwd_sel_o remains 1 and stall_cnt_o is unchanged.
  - After release, the pipeline resumes.
- Flush during a load-use stall:
  - Required: stall_o drops to 0 that cycle; the next fwd_sel_o=0; slot 0 holds a bubble.
- Reset and parameters:
  - Assert rst_i asynchronously mid-stall. Required: stall_o and fwd_sel_o go to 0 before the next edge.
  - Rerun the load-use test with STAGES=5, LOAD_LAT=2, NSRC=3. Required: 2 stall cycles, then sel=3.
